// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller: turns debug commands into the global pipeline enable and drains
// the pipeline behind a HALT seen in ID before freezing.
module pipeline_sequencer #(
    parameter int unsigned NB_count    = 32,
    parameter int unsigned N_DRAIN     = 3,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                in_clk,
    input  logic                in_reset,
    input  logic                in_cmd_valid,
    input  logic [1:0]          in_cmd,
    output logic                out_cmd_ready,
    input  logic [5:0]          in_opcode,
    output logic                out_enable,
    output logic                out_flush_ifid,
    output logic [NB_count-1:0] out_cycle_count,
    output logic [2:0]          out_state,
    output logic                out_done
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StDrain  = 3'd3,
        StHalted = 3'd4
    } state_e;

    localparam logic [1:0] CmdRun  = 2'b01;
    localparam logic [1:0] CmdStep = 2'b10;
    localparam logic [1:0] CmdStop = 2'b11;

    // Wide enough to hold N_DRAIN, and at least one bit when N_DRAIN is 0.
    localparam int unsigned DW = $clog2(N_DRAIN + 2);
    localparam logic [DW-1:0]       DrainOne = 1;
    localparam logic [DW-1:0]       DrainLoad = N_DRAIN[DW-1:0];
    localparam logic [NB_count-1:0] CountOne = 1;

    state_e        state;
    logic [DW-1:0] drain_cnt;
    logic          cmd_accept;
    logic          halt_seen;

    assign out_cmd_ready = (state == StIdle) || (state == StRun) || (state == StHalted);
    assign cmd_accept    = in_cmd_valid && out_cmd_ready;
    assign halt_seen     = (in_opcode == HALT_OPCODE);
    assign out_state     = state;

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state           <= StIdle;
            drain_cnt       <= '0;
            out_enable      <= 1'b0;
            out_flush_ifid  <= 1'b0;
            out_cycle_count <= '0;
            out_done        <= 1'b0;
        end else begin
            if (out_enable && (out_cycle_count != '1)) begin
                out_cycle_count <= out_cycle_count + CountOne;
            end
            out_done       <= 1'b0;
            out_flush_ifid <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (cmd_accept && (in_cmd == CmdRun)) begin
                        state      <= StRun;
                        out_enable <= 1'b1;
                    end else if (cmd_accept && (in_cmd == CmdStep)) begin
                        state      <= StStep;
                        out_enable <= 1'b1;
                    end
                end
                StRun, StStep: begin
                    // HALT wins over a STOP presented in the same cycle.
                    if (halt_seen) begin
                        if (N_DRAIN == 0) begin
                            state      <= StHalted;
                            out_enable <= 1'b0;
                            out_done   <= 1'b1;
                        end else begin
                            state          <= StDrain;
                            out_enable     <= 1'b1;
                            out_flush_ifid <= 1'b1;
                            drain_cnt      <= DrainLoad;
                        end
                    end else if ((state == StStep) || (cmd_accept && (in_cmd == CmdStop))) begin
                        state      <= StIdle;
                        out_enable <= 1'b0;
                    end
                end
                StDrain: begin
                    drain_cnt <= drain_cnt - DrainOne;
                    if (drain_cnt == DrainOne) begin
                        state      <= StHalted;
                        out_enable <= 1'b0;
                        out_done   <= 1'b1;
                    end else begin
                        out_flush_ifid <= 1'b1;
                    end
                end
                StHalted: begin
                    // Leaving HALTED flushes IF/ID once so a fresh fetch starts clean.
                    if (cmd_accept && (in_cmd == CmdStop)) begin
                        state          <= StIdle;
                        out_flush_ifid <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    out_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: three parameterisations share one random command/opcode stream; a reference
// model predicts each cycle's outputs and a monitor compares them after every clock edge.
module tb_pipeline_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [1:0] cmd;
    logic [5:0] opc;

    always #5 clk = ~clk;

    logic        rdy_a, en_a, fl_a, dn_a;
    logic        rdy_b, en_b, fl_b, dn_b;
    logic        rdy_c, en_c, fl_c, dn_c;
    logic [2:0]  st_a, st_b, st_c;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [7:0]  cnt_c;

    pipeline_sequencer #(.NB_count(32), .N_DRAIN(3), .HALT_OPCODE(6'b111111)) dut_a (
        .in_clk(clk), .in_reset(rst), .in_cmd_valid(vld), .in_cmd(cmd), .out_cmd_ready(rdy_a),
        .in_opcode(opc), .out_enable(en_a), .out_flush_ifid(fl_a), .out_cycle_count(cnt_a),
        .out_state(st_a), .out_done(dn_a));

    pipeline_sequencer #(.NB_count(4), .N_DRAIN(3), .HALT_OPCODE(6'b111111)) dut_b (
        .in_clk(clk), .in_reset(rst), .in_cmd_valid(vld), .in_cmd(cmd), .out_cmd_ready(rdy_b),
        .in_opcode(opc), .out_enable(en_b), .out_flush_ifid(fl_b), .out_cycle_count(cnt_b),
        .out_state(st_b), .out_done(dn_b));

    pipeline_sequencer #(.NB_count(8), .N_DRAIN(0), .HALT_OPCODE(6'b111111)) dut_c (
        .in_clk(clk), .in_reset(rst), .in_cmd_valid(vld), .in_cmd(cmd), .out_cmd_ready(rdy_c),
        .in_opcode(opc), .out_enable(en_c), .out_flush_ifid(fl_c), .out_cycle_count(cnt_c),
        .out_state(st_c), .out_done(dn_c));

    typedef struct packed {
        logic [2:0]  st;
        logic        en;
        logic        fl;
        logic        dn;
        logic        rdy;
        logic [31:0] cnt;
    } obs_t;

    obs_t act [3];
    assign act[0] = '{st: st_a, en: en_a, fl: fl_a, dn: dn_a, rdy: rdy_a, cnt: cnt_a};
    assign act[1] = '{st: st_b, en: en_b, fl: fl_b, dn: dn_b, rdy: rdy_b, cnt: {28'd0, cnt_b}};
    assign act[2] = '{st: st_c, en: en_c, fl: fl_c, dn: dn_c, rdy: rdy_c, cnt: {24'd0, cnt_c}};

    // Reference model: mode numbers are the published out_state values.
    int     nb_p [3] = '{32, 4, 8};
    int     nd_p [3] = '{3, 3, 0};
    int     m_mode [3];
    int     m_left [3];    // enabled drain cycles still owed
    bit     m_flush [3];
    bit     m_done [3];
    longint m_cnt [3];

    obs_t q [3][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    function automatic bit m_enabled(int i);
        return (m_mode[i] == 1) || (m_mode[i] == 2) || (m_mode[i] == 3);
    endfunction

    function automatic void enter_halt_path(int i);
        if (nd_p[i] == 0) begin
            m_mode[i] = 4;
            m_done[i] = 1;
        end else begin
            m_mode[i] = 3;
            m_left[i] = nd_p[i];
        end
    endfunction

    function automatic void model_step(int i, bit r, bit v, logic [1:0] c, logic [5:0] o);
        bit     accepted;
        longint cap;
        if (r) begin
            m_mode[i] = 0; m_left[i] = 0; m_flush[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
            return;
        end
        cap = (longint'(1) << nb_p[i]) - 1;
        if (m_enabled(i) && m_cnt[i] < cap) m_cnt[i] = m_cnt[i] + 1;
        accepted = v && (m_mode[i] == 0 || m_mode[i] == 1 || m_mode[i] == 4);
        m_flush[i] = 0;
        m_done[i] = 0;
        case (m_mode[i])
            0: if (accepted && c == 2'b01) m_mode[i] = 1;
               else if (accepted && c == 2'b10) m_mode[i] = 2;
            1: if (o == 6'h3f) enter_halt_path(i);
               else if (accepted && c == 2'b11) m_mode[i] = 0;
            2: if (o == 6'h3f) enter_halt_path(i);
               else m_mode[i] = 0;
            3: begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_mode[i] = 4;
                    m_done[i] = 1;
                end
            end
            4: if (accepted && c == 2'b11) begin
                m_mode[i] = 0;
                m_flush[i] = 1;
            end
            default: m_mode[i] = 0;
        endcase
        if (m_mode[i] == 3) m_flush[i] = 1;
    endfunction

    function automatic obs_t model_obs(int i);
        obs_t e;
        e.st  = 3'(m_mode[i]);
        e.en  = m_enabled(i);
        e.fl  = m_flush[i];
        e.dn  = m_done[i];
        e.rdy = (m_mode[i] == 0) || (m_mode[i] == 1) || (m_mode[i] == 4);
        e.cnt = 32'(m_cnt[i]);
        return e;
    endfunction

    task automatic drive(input bit r, input bit v, input logic [1:0] c, input logic [5:0] o);
        rst = r; vld = v; cmd = c; opc = o;
        for (int i = 0; i < 3; i++) begin
            model_step(i, r, v, c, o);
            q[i].push_back(model_obs(i));
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic [5:0] o);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'b00, o);
    endtask

    // Monitor: one expected record per instance per clock edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() != 0) begin
                    e = q[i].pop_front();
                    n_cmp++;
                    if (act[i] !== e) begin
                        n_bad++;
                        $display("FAIL inst%0d cycle %0d: got st=%0d en=%b fl=%b dn=%b rdy=%b cnt=%0d, want st=%0d en=%b fl=%b dn=%b rdy=%b cnt=%0d",
                                 i, cyc, act[i].st, act[i].en, act[i].fl, act[i].dn, act[i].rdy,
                                 act[i].cnt, e.st, e.en, e.fl, e.dn, e.rdy, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_left[i] = 0; m_flush[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
        end
        // Reset held two cycles while running.
        drive(1'b1, 1'b0, 2'b00, 6'h00);
        drive(1'b0, 1'b1, 2'b01, 6'h00);
        idle_cycles(2, 6'h00);
        drive(1'b1, 1'b0, 2'b00, 6'h00);
        drive(1'b1, 1'b0, 2'b00, 6'h00);
        // Three single steps on lw.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 2'b10, 6'h23);
            idle_cycles(2, 6'h23);
        end
        drive(1'b1, 1'b0, 2'b00, 6'h00);
        // RUN, HALT in the fifth enabled cycle, then drain.
        drive(1'b0, 1'b1, 2'b01, 6'h23);
        idle_cycles(4, 6'h23);
        drive(1'b0, 1'b0, 2'b00, 6'h3f);
        idle_cycles(5, 6'h3f);
        // Commands while halted, then STOP.
        drive(1'b0, 1'b1, 2'b01, 6'h00);
        drive(1'b0, 1'b1, 2'b10, 6'h00);
        drive(1'b0, 1'b1, 2'b11, 6'h00);
        idle_cycles(2, 6'h00);
        // RUN then STOP on the fourth enabled cycle; RUN again with STOP coinciding with HALT.
        drive(1'b0, 1'b1, 2'b01, 6'h00);
        idle_cycles(3, 6'h00);
        drive(1'b0, 1'b1, 2'b11, 6'h00);
        drive(1'b0, 1'b1, 2'b01, 6'h00);
        idle_cycles(2, 6'h00);
        drive(1'b0, 1'b1, 2'b11, 6'h3f);
        idle_cycles(5, 6'h00);
        drive(1'b0, 1'b1, 2'b11, 6'h00);
        // Long run without HALT to saturate the narrow counter, then reset inside a drain.
        drive(1'b0, 1'b1, 2'b01, 6'h00);
        idle_cycles(20, 6'h00);
        drive(1'b0, 1'b0, 2'b00, 6'h3f);
        drive(1'b0, 1'b0, 2'b00, 6'h00);
        drive(1'b1, 1'b0, 2'b00, 6'h00);
        idle_cycles(4, 6'h00);
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] o;
            o = ($urandom_range(0, 9) == 0) ? 6'h3f : 6'($urandom_range(0, 62));
            drive(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom), o);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (q[i].size() != 0) begin
                n_bad++;
                $display("FAIL drain_queue inst%0d: got %0d unchecked entries, want 0", i,
                         q[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
